// File: rtl/rr_decode_arb8.sv
// rr_decode_arb8: eight-way round-robin arbiter with decoder-style active-low one-hot grant
// Ports: clk/rst (sync, active-high); req_[7:0] active-low requests; en gates new grants;
//        hold blocks timeout preemption; sel/gvalid registered grant index and valid;
//        y_ active-low one-hot of sel (8'hFF when idle); tout one-cycle timeout-release pulse.
module rr_decode_arb8 #(
  parameter int MAXHOLD = 16,
  parameter int TURN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req_,
  input  logic       en,
  input  logic       hold,
  output logic [2:0] sel,
  output logic       gvalid,
  output logic [7:0] y_,
  output logic       tout
);
  localparam int CW = MAXHOLD > 1 ? $clog2(MAXHOLD) : 1;
  localparam logic [CW-1:0] CMAX = CW'(MAXHOLD == 0 ? 0 : MAXHOLD - 1);
  localparam logic [1:0] TC0 = 2'(TURN == 0 ? 0 : TURN - 1);
  typedef enum logic [1:0] {IDLE, GRANT, TGAP} state_t;
  state_t state, n_state;
  logic [2:0] ptr, n_ptr, n_sel, win, idx;
  logic [CW-1:0] cnt, n_cnt;
  logic [1:0] tc, n_tc;
  logic [7:0] r, others;
  logic n_gv, n_tout, found, rel, to;
  assign r = ~req_;
  assign others = r & ~(8'b1 << sel);
  // Scan from the farthest offset down so the closest asserted index to ptr wins last.
  always_comb begin
    win = ptr;
    found = 1'b0;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      idx = ptr + 3'(i);
      if (r[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  assign rel = req_[sel];
  assign to = (MAXHOLD != 0) && (cnt == CMAX) && !hold && !req_[sel] && (others != 8'h00);
  always_comb begin
    n_state = state;
    n_sel = sel;
    n_gv = gvalid;
    n_tout = 1'b0;
    n_ptr = ptr;
    n_cnt = cnt;
    n_tc = tc;
    case (state)
      IDLE:
        if (en && found) begin
          n_sel = win;
          n_gv = 1'b1;
          n_cnt = '0;
          n_state = GRANT;
        end
      GRANT:
        if (rel || to) begin
          n_gv = 1'b0;
          n_ptr = sel + 3'd1;
          n_tout = to;
          n_tc = TC0;
          n_state = TURN == 0 ? IDLE : TGAP;
        end else begin
          n_cnt = cnt == CMAX ? cnt : cnt + CW'(1);
        end
      TGAP: begin
        n_state = tc == 2'd0 ? IDLE : TGAP;
        n_tc = tc == 2'd0 ? tc : tc - 2'd1;
      end
      default: n_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel <= 3'd0;
      gvalid <= 1'b0;
      y_ <= 8'hFF;
      tout <= 1'b0;
      ptr <= 3'd0;
      cnt <= '0;
      tc <= 2'd0;
    end else begin
      state <= n_state;
      sel <= n_sel;
      gvalid <= n_gv;
      y_ <= n_gv ? ~(8'b1 << n_sel) : 8'hFF;
      tout <= n_tout;
      ptr <= n_ptr;
      cnt <= n_cnt;
      tc <= n_tc;
    end
  end
endmodule

// File: tb/tb_rr_decode_arb8.sv
// tb_rr_decode_arb8: directed self-checking bench for three parameterisations of rr_decode_arb8
module tb_rr_decode_arb8;
  logic clk = 1'b0;
  logic rst, en, hold;
  logic [7:0] req_;
  logic [2:0] sel1, sel2, sel3;
  logic gv1, gv2, gv3, to1, to2, to3;
  logic [7:0] y1, y2, y3;
  int checks = 0;
  int failures = 0;
  int gap;
  logic [2:0] e;
  always #5 clk = ~clk;
  rr_decode_arb8 #(.MAXHOLD(16), .TURN(1)) u1 (.clk(clk), .rst(rst), .req_(req_), .en(en), .hold(hold),
    .sel(sel1), .gvalid(gv1), .y_(y1), .tout(to1));
  rr_decode_arb8 #(.MAXHOLD(4), .TURN(0)) u2 (.clk(clk), .rst(rst), .req_(req_), .en(en), .hold(hold),
    .sel(sel2), .gvalid(gv2), .y_(y2), .tout(to2));
  rr_decode_arb8 #(.MAXHOLD(16), .TURN(3)) u3 (.clk(clk), .rst(rst), .req_(req_), .en(en), .hold(hold),
    .sel(sel3), .gvalid(gv3), .y_(y3), .tout(to3));
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req_ = 8'hFF;
    tick(1);
    rst = 1'b0;
  endtask
  initial begin
    rst = 1'b1; en = 1'b1; hold = 1'b0; req_ = 8'hFF;
    tick(2);
    rst = 1'b0;
    req_ = 8'hEF;
    tick(1);
    chk("pre_reset_grant", {gv1, sel1}, {1'b1, 3'd4});
    rst = 1'b1; req_ = 8'h00;
    tick(2);
    chk("rst_y", y1, 8'hFF);
    chk("rst_gv", gv1, 1'b0);
    chk("rst_sel", sel1, 3'd0);
    chk("rst_tout", to1, 1'b0);
    chk("rst_u2u3", {y2, y3, gv2, gv3}, {8'hFF, 8'hFF, 1'b0, 1'b0});
    rst = 1'b0;
    tick(1);
    chk("first_grant_y", {gv1, sel1, y1}, {1'b1, 3'd0, 8'hFE});
    do_reset();
    req_ = 8'hF7;
    tick(1);
    chk("single_grant", {gv1, sel1, y1}, {1'b1, 3'd3, 8'hF7});
    req_ = 8'hFF;
    tick(1);
    chk("single_release", {gv1, y1}, {1'b0, 8'hFF});
    req_ = 8'hF7;
    tick(1);
    chk("single_gap", gv1, 1'b0);
    tick(1);
    chk("single_regrant", {gv1, sel1, y1}, {1'b1, 3'd3, 8'hF7});
    do_reset();
    req_ = 8'hDD;
    for (int i = 0; i < 4; i++) begin
      e = (i % 2) ? 3'd5 : 3'd1;
      tick(1);
      chk("rr_grant", {gv1, y1}, {1'b1, ~(8'b1 << e)});
      tick(1);
      chk("rr_grant2", {gv1, sel1}, {1'b1, e});
      req_ = 8'hDD | (8'b1 << e);
      tick(1);
      chk("rr_rel", gv1, 1'b0);
      req_ = 8'hDD;
      tick(1);
      chk("rr_gap", gv1, 1'b0);
    end
    do_reset();
    req_ = 8'hFB;
    tick(1);
    chk("to_grant", {gv2, sel2}, {1'b1, 3'd2});
    req_ = 8'hBB;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("to_hold", {gv2, sel2, to2}, {1'b1, 3'd2, 1'b0});
    end
    tick(1);
    chk("to_pulse", {gv2, to2, y2}, {1'b0, 1'b1, 8'hFF});
    tick(1);
    chk("to_next", {gv2, sel2, y2, to2}, {1'b1, 3'd6, 8'hBF, 1'b0});
    do_reset();
    req_ = 8'hFB;
    tick(1);
    req_ = 8'hBB; hold = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("hold_keep", {gv2, sel2, to2}, {1'b1, 3'd2, 1'b0});
    end
    req_ = 8'hBF;
    tick(1);
    chk("hold_rel", {gv2, to2}, {1'b0, 1'b0});
    tick(1);
    chk("hold_next", {gv2, sel2, y2}, {1'b1, 3'd6, 8'hBF});
    hold = 1'b0;
    do_reset();
    req_ = 8'hFB;
    tick(1);
    tick(5);
    chk("sat_persist", {gv2, sel2, to2}, {1'b1, 3'd2, 1'b0});
    req_ = 8'hBB;
    tick(1);
    chk("sat_preempt", {gv2, to2}, {1'b0, 1'b1});
    tick(1);
    chk("sat_tout_once", {gv2, sel2, to2}, {1'b1, 3'd6, 1'b0});
    do_reset();
    req_ = 8'hEE;
    tick(1);
    chk("turn3_first", {gv3, sel3}, {1'b1, 3'd0});
    for (int i = 0; i < 3; i++) begin
      e = (i % 2) ? 3'd0 : 3'd4;
      req_ = 8'hEE | (8'b1 << sel3);
      tick(1);
      req_ = 8'hEE;
      gap = 1;
      while (!gv3 && gap < 10) begin
        tick(1);
        if (!gv3) gap++;
      end
      chk("turn3_gap", gap, 4);
      chk("turn3_sel", {gv3, sel3}, {1'b1, e});
    end
    do_reset();
    en = 1'b0; req_ = 8'h00;
    tick(3);
    chk("en_off", gv1, 1'b0);
    en = 1'b1;
    tick(1);
    chk("en_on", {gv1, sel1, y1}, {1'b1, 3'd0, 8'hFE});
    en = 1'b0;
    tick(2);
    chk("en_midgrant", {gv1, sel1}, {1'b1, 3'd0});
    req_ = 8'hFF;
    tick(1);
    chk("en_rel", gv1, 1'b0);
    req_ = 8'h00;
    tick(3);
    chk("en_idle_blocked", gv1, 1'b0);
    en = 1'b1;
    tick(1);
    chk("en_ptr_next", {gv1, sel1, y1}, {1'b1, 3'd1, 8'hFD});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
